// File: rtl/rc4_sbox_ctrl.sv
// rc4_sbox_ctrl: sole master of the three-port RC4 S-box RAM. It fills the
// identity permutation (INIT), runs key scheduling (KSA) against an internal
// key file, then streams keystream bytes (PRGA) over a valid/ready handshake.
module rc4_sbox_ctrl #(
    parameter  int KEY_MAX_LEN = 32,
    localparam int KIW         = $clog2(KEY_MAX_LEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    // key file load port, IDLE only
    input  logic           key_wr,
    input  logic [KIW-1:0] key_waddr,
    input  logic [7:0]     key_wdata,
    input  logic [KIW:0]   key_len,
    // control
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           ks_mode,
    // keystream stream
    output logic           ks_valid,
    input  logic           ks_ready,
    output logic [7:0]     ks_data,
    // S-box RAM ports
    output logic [7:0]     sb_raddr_1,
    input  logic [7:0]     sb_rdata_1,
    output logic [7:0]     sb_waddr_2,
    output logic [7:0]     sb_wdata_2,
    output logic           sb_wen_2,
    output logic [7:0]     sb_addr_3,
    output logic [7:0]     sb_wdata_3,
    output logic           sb_wen_3,
    input  logic [7:0]     sb_rdata_3
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_KSA_A,
        S_KSA_B,
        S_KSA_C,
        S_KSA_W,
        S_P_A,
        S_P_B,
        S_P_C,
        S_P_W,
        S_P_K,
        S_P_O,
        S_OUT
    } state_t;

    localparam logic [KIW:0]   KLEN_MAX    = (KIW+1)'(KEY_MAX_LEN);
    localparam logic [KIW-1:0] KIDX_LAST   = KIW'(KEY_MAX_LEN - 1);

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     n;        // INIT fill counter
    logic [7:0]     i;
    logic [7:0]     j;
    logic [7:0]     t;        // PRGA output index
    logic [7:0]     si;       // S[i] captured for the swap
    logic [KIW-1:0] kidx;
    logic [KIW-1:0] klen_m1;  // last valid key index for this run
    logic [KIW:0]   klen_dec;

    logic [7:0]     key [KEY_MAX_LEN];

    assign busy     = (state != S_IDLE);
    assign klen_dec = key_len - 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state and RAM port drive; ports idle at zero outside their states
    always_comb begin
        state_nxt  = state;
        sb_raddr_1 = '0;
        sb_waddr_2 = '0;
        sb_wdata_2 = '0;
        sb_wen_2   = 1'b0;
        sb_addr_3  = '0;
        sb_wdata_3 = '0;
        sb_wen_3   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                sb_wen_2   = 1'b1;
                sb_waddr_2 = n;
                sb_wdata_2 = n;
                if (n == 8'hFF) state_nxt = S_KSA_A;
            end
            S_KSA_A: begin
                sb_raddr_1 = i;
                state_nxt  = S_KSA_B;
            end
            S_KSA_B: state_nxt = S_KSA_C;
            S_KSA_C: begin
                sb_addr_3 = j;
                state_nxt = S_KSA_W;
            end
            S_KSA_W: begin
                // swap: S[i] <= S[j] on port 2, S[j] <= S[i] on port 3
                sb_wen_2   = 1'b1;
                sb_waddr_2 = i;
                sb_wdata_2 = sb_rdata_3;
                sb_wen_3   = 1'b1;
                sb_addr_3  = j;
                sb_wdata_3 = si;
                state_nxt  = (i == 8'hFF) ? S_P_A : S_KSA_A;
            end
            S_P_A: begin
                sb_raddr_1 = i;
                state_nxt  = S_P_B;
            end
            S_P_B: state_nxt = S_P_C;
            S_P_C: begin
                sb_addr_3 = j;
                state_nxt = S_P_W;
            end
            S_P_W: begin
                sb_wen_2   = 1'b1;
                sb_waddr_2 = i;
                sb_wdata_2 = sb_rdata_3;
                sb_wen_3   = 1'b1;
                sb_addr_3  = j;
                sb_wdata_3 = si;
                state_nxt  = S_P_K;
            end
            S_P_K: begin
                // swap committed last edge, so S[t] already reflects it
                sb_raddr_1 = t;
                state_nxt  = S_P_O;
            end
            S_P_O: state_nxt = S_OUT;
            S_OUT: begin
                if (ks_ready) state_nxt = S_P_A;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // datapath registers: indices, swap operands and the output stream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n        <= '0;
            i        <= '0;
            j        <= '0;
            t        <= '0;
            si       <= '0;
            kidx     <= '0;
            klen_m1  <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
            ks_mode  <= 1'b0;
        end else if (abort) begin
            ks_valid <= 1'b0;
            ks_mode  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n    <= '0;
                        i    <= '0;
                        j    <= '0;
                        kidx <= '0;
                        // zero or oversize length means use the whole file
                        if (key_len == '0 || key_len > KLEN_MAX)
                            klen_m1 <= KIDX_LAST;
                        else
                            klen_m1 <= klen_dec[KIW-1:0];
                    end
                end
                S_INIT: n <= n + 8'd1;
                S_KSA_B: begin
                    si <= sb_rdata_1;
                    j  <= j + sb_rdata_1 + key[kidx];
                end
                S_KSA_W: begin
                    kidx <= (kidx == klen_m1) ? '0 : kidx + 1'b1;
                    if (i == 8'hFF) begin
                        // PRGA pre-increments i, so it starts at 1
                        i       <= 8'd1;
                        j       <= '0;
                        ks_mode <= 1'b1;
                    end else begin
                        i <= i + 8'd1;
                    end
                end
                S_P_B: begin
                    si <= sb_rdata_1;
                    j  <= j + sb_rdata_1;
                end
                S_P_W: t <= si + sb_rdata_3;
                S_P_O: begin
                    ks_data  <= sb_rdata_1;
                    ks_valid <= 1'b1;
                end
                S_OUT: begin
                    if (ks_ready) begin
                        ks_valid <= 1'b0;
                        i        <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // key file: not reset, only writable while idle
    always_ff @(posedge clk) begin
        if (key_wr && state == S_IDLE) key[key_waddr] <= key_wdata;
    end

endmodule

// File: tb/tb_rc4_sbox_ctrl.sv
// Bench for rc4_sbox_ctrl: behavioural 3-port S-box RAM, directed key vectors,
// a reference RC4 model for long runs, and a queue-based keystream scoreboard.
module tb_rc4_sbox_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, key_wr, start, abort, ks_ready;
    logic [4:0] key_waddr;
    logic [7:0] key_wdata;
    logic [5:0] key_len;
    logic       busy, ks_mode, ks_valid;
    logic [7:0] ks_data;
    logic [7:0] sb_raddr_1, sb_rdata_1, sb_waddr_2, sb_wdata_2;
    logic [7:0] sb_addr_3, sb_wdata_3, sb_rdata_3;
    logic       sb_wen_2, sb_wen_3;

    always #5 clk = ~clk;

    rc4_sbox_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr(key_wr), .key_waddr(key_waddr), .key_wdata(key_wdata), .key_len(key_len),
        .start(start), .abort(abort), .busy(busy), .ks_mode(ks_mode),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .sb_raddr_1(sb_raddr_1), .sb_rdata_1(sb_rdata_1),
        .sb_waddr_2(sb_waddr_2), .sb_wdata_2(sb_wdata_2), .sb_wen_2(sb_wen_2),
        .sb_addr_3(sb_addr_3), .sb_wdata_3(sb_wdata_3), .sb_wen_3(sb_wen_3),
        .sb_rdata_3(sb_rdata_3)
    );

    // S-box RAM: 1-cycle read latency, port 3 wins a same-address write
    logic [7:0] mem [256];
    always @(posedge clk) begin
        sb_rdata_1 <= mem[sb_raddr_1];
        sb_rdata_3 <= mem[sb_addr_3];
        if (sb_wen_2) mem[sb_waddr_2] <= sb_wdata_2;
        if (sb_wen_3) mem[sb_addr_3]  <= sb_wdata_3;
    end

    int         chk = 0;
    int         err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] kbuf [32];
    logic [7:0] ref_ks [300];
    int         rmode = 0;  // 0: ready high, 1: random, 2: ready low

    logic [7:0] v_key    [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    logic [7:0] v_12345  [8]  = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
    logic [7:0] v_wiki   [6]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    logic [7:0] v_secret [8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk++;
        if (act !== expv) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // consumer ready pattern
    initial begin
        ks_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       ks_ready = 1'b1;
                1:       ks_ready = 1'($urandom_range(0, 1));
                default: ks_ready = 1'b0;
            endcase
        end
    end

    // monitor: scoreboard pop, stall stability, RAM write legality
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [7:0] mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", ks_valid, 1);
                check("hold_data", ks_data, prev_data);
            end
            if (ks_valid && ks_ready) begin
                if (exp_q.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_byte: got %0h expected none", ks_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ks_data", ks_data, mon_e);
                end
            end
            if ((sb_wen_2 || sb_wen_3) && !busy) begin
                chk++; err++;
                $display("FAIL idle_write: got wen %0d%0d expected 00", sb_wen_2, sb_wen_3);
            end
            if (sb_wen_2 && sb_wen_3) begin
                check("swap_data2", sb_wdata_2, mem[sb_addr_3]);
                check("swap_data3", sb_wdata_3, mem[sb_waddr_2]);
            end else if (sb_wen_2) begin
                check("init_data", sb_wdata_2, sb_waddr_2);
            end else if (sb_wen_3) begin
                chk++; err++;
                $display("FAIL lone_wen3: got 1 expected 0");
            end
        end
        prev_stall = rst_n && ks_valid && !ks_ready && !abort;
        prev_data  = ks_data;
    end

    // reference RC4 over kbuf[0..klen-1]
    task automatic ref_gen(input int klen, input int nb);
        logic [7:0] s [256];
        logic [7:0] ri, rj, tmp;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        rj = 0;
        for (int k = 0; k < 256; k++) begin
            rj = rj + s[k] + kbuf[k % klen];
            tmp = s[k]; s[k] = s[rj]; s[rj] = tmp;
        end
        ri = 0; rj = 0;
        for (int b = 0; b < nb; b++) begin
            ri = ri + 8'd1;
            rj = rj + s[ri];
            tmp = s[ri]; s[ri] = s[rj]; s[rj] = tmp;
            tmp = s[ri] + s[rj];
            ref_ks[b] = s[tmp];
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_key(input int len);
        for (int k = 0; k < len; k++) begin
            key_wr = 1'b1; key_waddr = 5'(k); key_wdata = kbuf[k];
            tick();
        end
        key_wr = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        key_len = 6'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(); c++;
        end
        if (exp_q.size() != 0) begin
            chk++; err++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_ks_mode"}, ks_mode, 0);
        check({p, "_ks_valid"}, ks_valid, 0);
        check({p, "_wen2"}, sb_wen_2, 0);
        check({p, "_wen3"}, sb_wen_3, 0);
        check({p, "_ks_data"}, ks_data, 0);
        check({p, "_raddr1"}, sb_raddr_1, 0);
        check({p, "_waddr2"}, sb_waddr_2, 0);
        check({p, "_wdata2"}, sb_wdata_2, 0);
        check({p, "_addr3"}, sb_addr_3, 0);
        check({p, "_wdata3"}, sb_wdata_3, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; key_wr = 1'b0; key_waddr = '0; key_wdata = '0;
        key_len = '0; start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        // start under reset is ignored
        start = 1'b1; tick(); start = 1'b0; tick();
        check("start_in_reset_busy", busy, 0);
        rst_n = 1'b1; tick();
        check_zero("reset");
        // abort beats start
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        check("abort_start_busy", busy, 0);

        // "Key", ready high, first-byte latency
        kbuf[0] = 8'h4B; kbuf[1] = 8'h65; kbuf[2] = 8'h79;
        load_key(3);
        foreach (v_key[k]) exp_q.push_back(v_key[k]);
        pulse_start(3);
        check("busy_after_start", busy, 1);
        cnt = 0;
        while (!ks_valid && cnt < 2000) begin tick(); cnt++; end
        check("first_valid_cycle", cnt, 1286);
        check("ks_mode_set", ks_mode, 1);
        wait_drain(200);
        pulse_abort();

        // 01..05, random ready, key write and start while busy ignored
        for (int k = 0; k < 5; k++) kbuf[k] = 8'(k + 1);
        load_key(5);
        rmode = 1;
        foreach (v_12345[k]) exp_q.push_back(v_12345[k]);
        pulse_start(5);
        key_wr = 1'b1; key_waddr = 5'd0; key_wdata = 8'hFF; tick(); key_wr = 1'b0;
        repeat (500) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_drain(1600);
        pulse_abort();
        rmode = 0;

        // "Wiki", then abort while stalled in OUT
        kbuf[0] = 8'h57; kbuf[1] = 8'h69; kbuf[2] = 8'h6B; kbuf[3] = 8'h69;
        load_key(4);
        foreach (v_wiki[k]) exp_q.push_back(v_wiki[k]);
        pulse_start(4);
        wait_drain(1500);
        rmode = 2;
        cnt = 0;
        while (!ks_valid && cnt < 30) begin tick(); cnt++; end
        check("stall_valid", ks_valid, 1);
        pulse_abort();
        check("abort_ks_valid", ks_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ks_mode", ks_mode, 0);
        check("abort_wen2", sb_wen_2, 0);
        check("abort_wen3", sb_wen_3, 0);
        rmode = 0;

        // "Secret"
        kbuf[0] = 8'h53; kbuf[1] = 8'h65; kbuf[2] = 8'h63;
        kbuf[3] = 8'h72; kbuf[4] = 8'h65; kbuf[5] = 8'h74;
        load_key(6);
        foreach (v_secret[k]) exp_q.push_back(v_secret[k]);
        pulse_start(6);
        wait_drain(1500);
        pulse_abort();

        // 32-byte key: lengths 0, 32 and 40 must agree
        for (int k = 0; k < 32; k++) kbuf[k] = 8'(k * 7 + 3);
        load_key(32);
        ref_gen(32, 16);
        foreach (v_key[r]) begin end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) exp_q.push_back(ref_ks[k]);
            pulse_start(r == 0 ? 0 : (r == 1 ? 32 : 40));
            wait_drain(1600);
            pulse_abort();
        end

        // long run across the i wrap
        for (int k = 0; k < 5; k++) kbuf[k] = 8'(k + 1);
        load_key(5);
        ref_gen(5, 300);
        for (int k = 0; k < 300; k++) exp_q.push_back(ref_ks[k]);
        pulse_start(5);
        wait_drain(4000);
        pulse_abort();

        // reset mid-KSA clears everything
        pulse_start(5);
        repeat (400) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_zero("midreset");

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
